// File: rtl/fetch_unit.sv
// fetch_unit: program counter and req/ack instruction fetch for the single-cycle MIPS core.
// Loads the next-PC mux output on commit and flags misaligned PCs and fetch timeouts.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic [31:0] npc_i,
   input  logic        commit_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] pc_o,
   output logic [31:0] pc4_o,
   output logic [31:0] inst_o,
   output logic        inst_valid_o,
   output logic        misalign_o,
   output logic        bus_err_o
);
   typedef enum logic [1:0] {IDLE, FETCH, READY, HALT} state_e;
   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d, inst_q, inst_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_q, req_d, valid_q, valid_d, mis_q, mis_d, berr_q, berr_d;
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      inst_d  = inst_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      valid_d = valid_q;
      mis_d   = mis_q;
      berr_d  = berr_q;
      case (state_q)
         IDLE: begin
            state_d = (pc_q[1:0] != 2'b00) ? HALT : FETCH;
            mis_d   = (pc_q[1:0] != 2'b00);
            req_d   = (pc_q[1:0] == 2'b00);
            cnt_d   = '0;
         end
         FETCH: begin
            // an ack on the final timeout cycle still wins
            if (imem_ack_i) begin
               inst_d  = imem_rdata_i;
               valid_d = 1'b1;
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = READY;
            end else if (cnt_q == CNT_LAST) begin
               berr_d  = 1'b1;
               req_d   = 1'b0;
               state_d = HALT;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         READY: begin
            if (commit_i) begin
               pc_d    = npc_i;
               valid_d = 1'b0;
               mis_d   = (npc_i[1:0] != 2'b00);
               req_d   = (npc_i[1:0] == 2'b00);
               cnt_d   = '0;
               state_d = (npc_i[1:0] != 2'b00) ? HALT : FETCH;
            end
         end
         default: begin
            req_d   = 1'b0;
            valid_d = 1'b0;
         end
      endcase
   end
   always_ff @(posedge clock_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         pc_q    <= RESET_PC;
         inst_q  <= '0;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         mis_q   <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         inst_q  <= inst_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         valid_q <= valid_d;
         mis_q   <= mis_d;
         berr_q  <= berr_d;
      end
   end
   assign imem_req_o   = req_q;
   assign imem_addr_o  = pc_q;
   assign pc_o         = pc_q;
   assign pc4_o        = pc_q + 32'd4;
   assign inst_o       = inst_q;
   assign inst_valid_o = valid_q;
   assign misalign_o   = mis_q;
   assign bus_err_o    = berr_q;
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Holds the program counter and fetches instructions for the single-cycle MIPS core.
- Sits directly downstream of the 32-bit 4:1 next-PC mux, which selects among pc+4, branch target, jr target and jump target.
- Registers the mux output into the PC when the current instruction commits.
- Runs a req/ack handshake with instruction memory and presents the fetched word to decode with a valid flag.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT, 255, maximum FETCH cycles without imem_ack before a bus error; legal range 2..65535.

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- npc  input  32  next PC from the next-PC mux output.
- commit  input  1  current instruction retired; load npc into the PC.
- imem_req  output  1  fetch request, registered.
- imem_addr  output  32  fetch address; equals pc.
- imem_ack  input  1  memory returns data this cycle.
- imem_rdata  input  32  instruction word, valid when imem_ack=1.
- pc  output  32  current PC.
- pc4  output  32  pc+4, combinational, feeds mux input a0.
- inst  output  32  instruction register.
- inst_valid  output  1  inst holds the word for the current pc.
- misalign  output  1  sticky: PC not word-aligned.
- bus_err  output  1  sticky: fetch timeout.

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high; it wins over every other input.
- Reset values:
  - pc=RESET_PC, inst=0, inst_valid=0, imem_req=0.
  - misalign=0, bus_err=0.
  - state=IDLE, timeout counter=0.
- States are IDLE, FETCH, READY and HALT.
- IDLE (one cycle after reset deasserts):
  - If pc[1:0]!=0, go to HALT and set misalign=1.
  - Otherwise go to FETCH and set imem_req=1 on the same edge.
- FETCH:
  - imem_req=1; imem_addr=pc, held stable until ack.
  - On imem_ack=1: inst<=imem_rdata, inst_valid<=1, imem_req<=0, counter<=0, go to READY.
  - While ack is absent the counter increments.
  - If the counter reaches TIMEOUT-1 with no ack, that edge sets bus_err=1, drops imem_req and goes to HALT.
  - An ack on that same edge takes priority over the timeout.
- READY:
  - inst_valid=1, imem_req=0; waits indefinitely for commit.
  - On commit=1: pc<=npc and inst_valid<=0.
  - If npc[1:0]!=0, go to HALT with misalign=1. pc still takes npc, for debug visibility.
  - Otherwise go to FETCH with imem_req=1 on the same edge.
- HALT: imem_req=0, inst_valid=0, flags held. Only reset exits HALT.
- Ignored inputs:
  - imem_ack outside FETCH is ignored; inst is unchanged.
  - commit outside READY is ignored; pc is unchanged.
  - commit and imem_ack arriving together are resolved by the current state only.
- Latency:
  - ack at edge N gives inst_valid=1 from N.
  - commit at edge M gives imem_req=1 with the new imem_addr from M.
  - Minimum instruction period is 2 cycles: ack, then commit.
- Arithmetic: pc4 = pc+4 modulo 2^32; 32'hFFFF_FFFC gives pc4=0. A wrapped npc=0 is fetched normally.
- Reset mid-operation: reset asserted during FETCH or READY drops imem_req and inst_valid at that edge and reloads RESET_PC.
- Counter width is 16 bits; the counter clears on every entry to FETCH.

Test Plan:
1. Reset, then ack on the 3rd FETCH cycle with rdata=32'h2008_0005.
   -> imem_addr=0, inst=32'h2008_0005, inst_valid=1, pc4=4.
2. Four commits with npc=4, 8, 0x40, 0x100; imem acks every cycle.
   -> imem_addr follows 4, 8, 0x40, 0x100; each instruction completes in 2 cycles.
3. Hold imem_ack=0 with TIMEOUT=8.
   -> bus_err=1 after the 8th FETCH cycle, imem_req=0.
   -> Later acks and commits are ignored until reset.
4. Commit with npc=32'h0000_0006.
   -> misalign=1, pc=6, state HALT, no further imem_req.
   -> Reset restores pc=0 and clears both flags.
5. Assert commit during FETCH, and pulse imem_ack during READY.
   -> pc and inst are unchanged by either.
6. Assert reset mid-FETCH at pc=0x40.
   -> imem_req=0 on the next edge, pc=RESET_PC, a fresh fetch of 0 follows.
   -> With pc=32'hFFFF_FFFC, pc4 reads 0.
